// File: rtl/alu_cmd_sequencer.sv
// Queued command driver for an 8-bit fixed-latency ALU with valid/ready on both sides.
// Optional ALU_SELF_CHECK_EN adds a reference model that flags a sticky mismatch.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_func,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_func,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic [2:0] rsp_func,
  output logic       busy,
  output logic       mismatch
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [18:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    lat_cnt;

  logic push, pop, lat_done;
  logic issue, capture, release_rsp;

  assign cmd_ready = (count != (AW+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign lat_done  = (lat_cnt == 4'(ALU_LAT - 1));
  assign busy      = (state != S_IDLE) || (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (count != '0) state_nxt = S_WAIT;
      S_WAIT: if (lat_done) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue       = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    unique case (state)
      S_IDLE: issue = (count != '0);
      S_WAIT: capture = lat_done;
      S_RESP: release_rsp = rsp_ready;
      default: ;
    endcase
  end

  assign pop = issue;

  // Storage has no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_func};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_func  <= '0;
      lat_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_func  <= '0;
    end else begin
      if (issue) begin
        {alu_a, alu_b, alu_func} <= mem[rd_ptr];
        lat_cnt <= '0;
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (capture) begin
        rsp_data  <= alu_out;
        rsp_carry <= alu_carry;
        rsp_func  <= alu_func;
        rsp_valid <= 1'b1;
      end else if (release_rsp) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SELF_CHECK_EN
  logic [8:0] ref_res;
  logic       ref_err;

  always_comb begin
    ref_res = '0;
    unique case (alu_func)
      3'b000: ref_res = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: ref_res = {1'b0, alu_a - alu_b};
      3'b010: ref_res = {1'b0, alu_a};
      3'b011: ref_res = {1'b0, alu_a[6:0], 1'b0};
      3'b100: ref_res = {2'b00, alu_a[7:1]};
      3'b101: ref_res = {1'b0, alu_a & alu_b};
      3'b110: ref_res = {1'b0, ~alu_a};
      3'b111: ref_res = {1'b0, alu_a | alu_b};
      default: ref_res = '0;
    endcase
  end

  // Carry is only meaningful for add.
  assign ref_err = (ref_res[7:0] != alu_out) ||
                   ((alu_func == 3'b000) && (ref_res[8] != alu_carry));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    mismatch <= 1'b0;
    else if (capture && ref_err) mismatch <= 1'b1;
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule
